// File: rtl/alu_seq_unit.sv
// Sequential ALU: operands load on strobe rising edges, logic/arith ops finish in one
// EXEC cycle, shifts/rotate step one bit per EXEC cycle through a working register.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       op,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             go,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] f_q,
    output logic [3:0]       fr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_d, b_d, f_d;
    logic [3:0]       fr_q, fr_d;
    logic             done_q, done_d, err_q, err_d;
    logic             lda_h_q, ldb_h_q, go_h_q;

    logic             lda_e, ldb_e, go_e;
    logic [WIDTH-1:0] a_new, b_new;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] w_step;
    logic             sh_out;
    logic [WIDTH-1:0] res;
    logic             of_f, cf_f, fin;

    assign lda_e = ld_a & ~lda_h_q;
    assign ldb_e = ld_b & ~ldb_h_q;
    assign go_e  = go & ~go_h_q;

    assign fr   = fr_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q == EXEC);

    always_comb begin
        a_new    = lda_e ? din : a_q;
        b_new    = ldb_e ? din : b_q;
        add_full = {1'b0, a_q} + {1'b0, b_q};
        diff     = a_q - b_q;

        w_step = w_q;
        sh_out = 1'b0;
        case (op_q[1:0])
            2'd0: begin w_step = {w_q[WIDTH-2:0], 1'b0};       sh_out = w_q[WIDTH-1]; end
            2'd1: begin w_step = {1'b0, w_q[WIDTH-1:1]};       sh_out = w_q[0];       end
            2'd2: begin w_step = {w_q[WIDTH-1], w_q[WIDTH-1:1]}; sh_out = w_q[0];     end
            default: begin w_step = {w_q[WIDTH-2:0], w_q[WIDTH-1]}; sh_out = w_q[WIDTH-1]; end
        endcase

        res  = '0;
        of_f = 1'b0;
        cf_f = 1'b0;
        fin  = 1'b1;
        case (op_q)
            4'd0: res = a_q & b_q;
            4'd1: res = a_q | b_q;
            4'd2: res = a_q ^ b_q;
            4'd3: res = ~(a_q | b_q);
            4'd4: begin
                res  = add_full[WIDTH-1:0];
                cf_f = add_full[WIDTH];
                of_f = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd5: begin
                res  = diff;
                cf_f = (a_q < b_q);
                of_f = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd6: res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            4'd7: res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd8, 4'd9, 4'd10, 4'd11: begin
                // a zero shift amount still spends one EXEC cycle and returns A untouched
                if (cnt_q == '0) begin
                    res = w_q;
                end else begin
                    res  = w_step;
                    cf_f = sh_out;
                    fin  = (cnt_q == SHW'(1));
                end
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        fr_d    = fr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                a_d = a_new;
                b_d = b_new;
                if (go_e) begin
                    op_d    = op;
                    w_d     = a_new;
                    cnt_d   = b_new[SHW-1:0];
                    state_d = EXEC;
                end
            end
            default: begin
                if (fin) begin
                    f_d     = res;
                    fr_d    = {(res == '0), res[WIDTH-1], of_f, cf_f};
                    done_d  = 1'b1;
                    err_d   = (op_q[3:2] == 2'b11);
                    state_d = IDLE;
                end else begin
                    w_d   = w_step;
                    cnt_d = cnt_q - SHW'(1);
                end
            end
        endcase
    end

    // strobe history resets high so a strobe held through reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            fr_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lda_h_q <= 1'b1;
            ldb_h_q <= 1'b1;
            go_h_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            fr_q    <= fr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lda_h_q <= ld_a;
            ldb_h_q <= ld_b;
            go_h_q  <= go;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: stimulus pushes expected results, a negedge
// monitor pops and compares whenever done is high.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [3:0]  op;
    logic        ld_a, ld_b, go;
    logic [31:0] a_q, b_q, f_q;
    logic [3:0]  fr;
    logic        busy, done, err;

    typedef struct packed {
        logic [31:0] f;
        logic [3:0]  fr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .op(op),
        .ld_a(ld_a), .ld_b(ld_b), .go(go),
        .a_q(a_q), .b_q(b_q), .f_q(f_q), .fr(fr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s: got %0h", nm, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && err) chk("err_with_done", done, 1);
        if (rst_n && done) begin
            chk("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_f", f_q, e.f);
                chk("sb_fr", fr, e.fr);
                chk("sb_err", err, e.err);
            end
        end
    end

    task automatic load_a(input logic [31:0] v);
        din = v; ld_a = 1'b1;
        @(posedge clk); #1;
        ld_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_b(input logic [31:0] v);
        din = v; ld_b = 1'b1;
        @(posedge clk); #1;
        ld_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] ef, input logic [3:0] efr,
                          input logic eerr, input int ebusy, input logic with_lda,
                          input logic [31:0] d, input logic interfere, input string nm);
        int cnt;
        sb.push_back('{f: ef, fr: efr, err: eerr});
        op = o; go = 1'b1;
        if (with_lda) begin din = d; ld_a = 1'b1; end
        @(posedge clk); #1;
        go = 1'b0; ld_a = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (interfere && (cnt % 4 == 1)) begin go = 1'b1; ld_a = 1'b1; din = 32'hDEADBEEF; end
            if (interfere && (cnt % 4 == 2)) begin go = 1'b0; ld_a = 1'b0; end
            @(posedge clk); #1;
        end
        go = 1'b0; ld_a = 1'b0;
        $display("op %0d %s: busy %0d cycles f_q=%h fr=%b", o, nm, cnt, f_q, fr);
        chk({nm, "_busy_cycles"}, cnt, ebusy);
        chk({nm, "_done_at_end"}, done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        rst_n = 1'b0; din = 32'h1234; op = 4'd0; ld_a = 1'b1; ld_b = 1'b0; go = 1'b0;
        #12;
        chk("rst_a", a_q, 0);
        chk("rst_b", b_q, 0);
        chk("rst_f", f_q, 0);
        chk("rst_flags", {fr, busy, done, err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held_strobe_no_load", a_q, 0);
        ld_a = 1'b0;
        @(posedge clk); #1;

        load_a(32'h7FFFFFFF); load_b(32'h1);
        run_op(4'd4, 32'h80000000, 4'b0110, 1'b0, 1, 1'b0, 0, 1'b0, "add_ovf");
        load_a(32'h5); load_b(32'h7);
        run_op(4'd5, 32'hFFFFFFFE, 4'b0101, 1'b0, 1, 1'b0, 0, 1'b0, "sub_borrow");
        load_a(32'hFFFFFFFF); load_b(32'h1);
        run_op(4'd7, 32'h1, 4'b0000, 1'b0, 1, 1'b0, 0, 1'b0, "slt");
        run_op(4'd6, 32'h0, 4'b1000, 1'b0, 1, 1'b0, 0, 1'b0, "sltu");
        run_op(4'd4, 32'h0, 4'b1001, 1'b0, 1, 1'b0, 0, 1'b0, "add_carry");
        load_a(32'hF0F0F0F0); load_b(32'hFF00FF00);
        run_op(4'd0, 32'hF000F000, 4'b0100, 1'b0, 1, 1'b0, 0, 1'b0, "and");
        run_op(4'd1, 32'hFFF0FFF0, 4'b0100, 1'b0, 1, 1'b0, 0, 1'b0, "or");
        run_op(4'd2, 32'h0FF00FF0, 4'b0000, 1'b0, 1, 1'b0, 0, 1'b0, "xor");
        run_op(4'd3, 32'h000F000F, 4'b0000, 1'b0, 1, 1'b0, 0, 1'b0, "nor");

        load_a(32'h80000001); load_b(32'd31);
        run_op(4'd10, 32'hFFFFFFFF, 4'b0100, 1'b0, 31, 1'b0, 0, 1'b1, "sra31_interfered");
        chk("a_unchanged_during_exec", a_q, 32'h80000001);
        load_b(32'd0);
        run_op(4'd8, 32'h80000001, 4'b0100, 1'b0, 1, 1'b0, 0, 1'b0, "sll0");
        load_b(32'd1);
        run_op(4'd11, 32'h00000003, 4'b0001, 1'b0, 1, 1'b0, 0, 1'b0, "rol1");
        load_a(32'hF); load_b(32'd4);
        run_op(4'd9, 32'h0, 4'b1001, 1'b0, 4, 1'b0, 0, 1'b0, "srl4");
        load_a(32'h3); load_b(32'd31);
        run_op(4'd8, 32'h80000000, 4'b0101, 1'b0, 31, 1'b0, 0, 1'b0, "sll31");
        run_op(4'd4, 32'h29, 4'b0000, 1'b0, 1, 1'b1, 32'd10, 1'b0, "add_coincident_ld");
        chk("coincident_a", a_q, 32'd10);
        run_op(4'd13, 32'h0, 4'b1000, 1'b1, 1, 1'b0, 0, 1'b0, "reserved13");

        load_a(32'h5); load_b(32'd20);
        op = 4'd8; go = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_busy_before_reset", busy, 1);
        rst_n = 1'b0; #1;
        chk("abort_a", a_q, 0);
        chk("abort_b", b_q, 0);
        chk("abort_f", f_q, 0);
        chk("abort_flags", {fr, busy, done, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || done) nb++;
        end
        $display("abort: go held high, busy/done cycles after release=%0d", nb);
        chk("no_restart_while_go_held", nb, 0);
        chk("abort_f_stays_zero", {f_q, fr}, 0);
        go = 1'b0;
        @(posedge clk); #1;
        run_op(4'd8, 32'h0, 4'b1000, 1'b0, 1, 1'b0, 0, 1'b0, "restart_after_go_fall");

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
